dmem8_word_ctrl: RTL
====================

Name: dmem8_word_ctrl

Overview:
- Sequencer between the CPU load/store stage and the 8 KB byte-wide data memory, which reads on negedge when re is asserted.
- Splits each byte, halfword or word request into consecutive single-byte memory cycles, little-endian.
- Assembles load data and applies sign or zero extension.
- Yields the memory to the debug boot port while debug is high.

Parameters:
- ADDR_W, 13: byte address width. Memory depth is 2**ADDR_W.
- DATA_W, 32: CPU-side data width. Fixed at 32; the parameter exists for documentation only.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  access request; held until ack.
- we  input  1  1 = store, 0 = load; sampled with req.
- size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- uns  input  1  load zero-extends when 1, sign-extends when 0.
- addr  input  ADDR_W  byte address of the access.
- wdata  input  32  store data; the low size bytes are used.
- rdata  output  32  extended load data; valid while ack=1.
- ack  output  1  one-cycle completion pulse.
- err  output  1  valid with ack; 1 = misaligned or illegal size, no memory access performed.
- busy  output  1  high from the accept cycle through the ack cycle.
- debug  input  1  boot/debug owns memory while high.
- mem_addr  output  ADDR_W  to memory addr.
- mem_re  output  1  to memory re.
- mem_we  output  1  to memory we.
- mem_wdata  output  8  to memory wdata.
- mem_rdata  input  8  from memory rdata.

Behaviour:
- Reset: state=IDLE, ack=0, err=0, busy=0, rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0. Counter and capture registers clear.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Accept at a posedge where req=1 and debug=0.
  - Latch we, size, uns, addr, wdata. Set N = 1/2/4 for size 00/01/10. Clear counter i.
  - If size=11, or (size=01 and addr[0]=1), or (size=10 and addr[1:0]≠0): go to RESP with err=1.
  - Otherwise go to ACCESS.
- ACCESS, cycle i (0..N-1), outputs driven from registers:
  - mem_addr = base+i. No wrap is possible because accesses are aligned.
  - Load: mem_re=1. The memory updates mem_rdata at the mid-cycle negedge; the closing posedge captures mem_rdata into byte lane i.
  - Store: mem_we=1, mem_wdata = wdata[8i+7:8i].
  - When i=N-1 at the posedge, go to RESP.
- Debug stall: while debug=1 in ACCESS, mem_re=0, mem_we=0, i holds and no byte is captured. The access resumes at the same i once debug=0. A byte whose cycle is cut by debug is repeated.
- RESP: ack=1 for exactly one cycle, err as determined, then go to IDLE.
  - Load rdata: byte = lane0 extended from bit 7; half = lanes1:0 extended from bit 15; word = lanes3:0.
  - Store, or err=1: rdata=0.
- Latency, counted from the accept edge: ack is high N+1 cycles later when there is no debug stall (byte=2, half=3, word=5). An error response is acked in the next cycle.
- req held after ack: the next access is accepted in the IDLE cycle that follows. Back-to-back throughput is N+2 cycles per access.
- req=1 with debug=1 in IDLE: not accepted; waits.
- rst asserted mid-ACCESS: immediate return to IDLE. No ack. Bytes already stored stay written.
- Outside ACCESS: mem_re=0 and mem_we=0 always.

Decomposition:
- Package dmem8_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - state enum (IDLE/ACCESS/RESP);
  - function size_to_n;
  - function misaligned(size, addr[1:0]).
- One sub-module, dmem8_load_ext: combinational merge and sign/zero extension of the captured lanes by size/uns.

Test Plan:
- Word store then word load: store addr=0x0010, wdata=0xDEADBEEF. Memory bytes 0x10..0x13 must equal EF,BE,AD,DE. The load must return rdata=0xDEADBEEF, with ack 5 cycles after accept and err=0.
- Sign versus zero extension: byte 0x80 stored at 0x0021. Byte load with uns=0 must return 0xFFFFFF80; with uns=1 it must return 0x00000080. Half load of 0x8001 at 0x0022 with uns=0 must return 0xFFFF8001.
- Misaligned and illegal requests, each must give ack next cycle with err=1 and no mem_re/mem_we pulse:
  - half at 0x0003;
  - word at 0x0006;
  - size=11.
- Debug stall: debug=1 for 3 cycles during byte 2 of a word load at 0x1FFC. mem_re must be low for those cycles, the byte count must resume at 2, ack must arrive 8 cycles after accept, and data must be correct.
- Reset mid-operation: rst pulse during byte 1 of a word store. State must be IDLE, there must be no ack, only byte 0 is written, and the next request completes normally.
- Back-to-back: req held high for 3 byte loads at 0x0000/0x0001/0x0002. There must be three acks, 3 cycles apart, with correct data.

Source files
------------

// File: rtl/dmem8_pkg.sv
// Shared encodings and helpers for the byte-serial data memory sequencer.
package dmem8_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    // Number of byte cycles for a size code; the illegal code never reaches ACCESS.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/dmem8_word_ctrl_if.sv
// CPU load/store request/response bundle for the data memory sequencer.
interface dmem8_word_ctrl_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic              busy;

    modport master (
        output req, we, size, uns, addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, size, uns, addr, wdata,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/dmem8_load_ext.sv
// Merges captured byte lanes into a load result with sign or zero extension.
module dmem8_load_ext
    import dmem8_pkg::*;
(
    input  logic [31:0] lanes_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);
    logic sign_b, sign_h;

    assign sign_b = ~uns_i & lanes_i[7];
    assign sign_h = ~uns_i & lanes_i[15];

    always_comb begin
        case (size_i)
            SZ_BYTE: data_o = {{24{sign_b}}, lanes_i[7:0]};
            SZ_HALF: data_o = {{16{sign_h}}, lanes_i[15:0]};
            default: data_o = lanes_i;
        endcase
    end
endmodule

// File: rtl/dmem8_word_ctrl.sv
// Splits CPU byte/half/word accesses into little-endian byte cycles on an 8-bit memory.
module dmem8_word_ctrl
    import dmem8_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    dmem8_word_ctrl_if.slave  cpu,
    input  logic              debug,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    state_e            state_q, state_d;
    logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]        size_q, size_d, i_q, i_d, last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, lanes_q, lanes_d, ext_data;
    logic              accept, bad_req, in_access;
    logic [2:0]        n_req;

    assign accept    = (state_q == IDLE) && cpu.req && !debug;
    assign n_req     = size_to_n(cpu.size);
    assign bad_req   = (cpu.size == SZ_ILL) || misaligned(cpu.size, cpu.addr[1:0]);
    assign in_access = (state_q == ACCESS);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        i_d     = i_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lanes_d = lanes_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = cpu.we;
                    uns_d   = cpu.uns;
                    size_d  = cpu.size;
                    addr_d  = cpu.addr;
                    wdata_d = cpu.wdata;
                    last_d  = 2'(n_req - 3'd1);
                    i_d     = '0;
                    lanes_d = '0;
                    err_d   = bad_req;
                    state_d = bad_req ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                // A debug cycle neither advances nor captures, so the byte is retried.
                if (!debug) begin
                    if (!we_q)
                        lanes_d[{i_q, 3'b000} +: 8] = mem_rdata;
                    if (i_q == last_q)
                        state_d = RESP;
                    else
                        i_d = i_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            i_q     <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            i_q     <= i_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lanes_q <= lanes_d;
        end
    end

    dmem8_load_ext u_load_ext (
        .lanes_i (lanes_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .data_o  (ext_data)
    );

    // Aligned accesses never cross a word, so base+i cannot wrap.
    assign mem_addr  = addr_q + ADDR_W'(i_q);
    assign mem_wdata = wdata_q[{i_q, 3'b000} +: 8];
    assign mem_re    = in_access && !we_q && !debug;
    assign mem_we    = in_access &&  we_q && !debug;

    assign cpu.ack   = (state_q == RESP);
    assign cpu.err   = (state_q == RESP) && err_q;
    assign cpu.rdata = ((state_q == RESP) && !we_q && !err_q) ? ext_data : '0;
    assign cpu.busy  = (state_q != IDLE) || accept;
endmodule
